c2sif_arb: RTL
==============

C2SIF_ARB -- requirements
Module: c2sif_arb

Interface
- REQ-001: Parameter NREQ, default 4, SHALL set the number of requester ports sharing one c2sif target.
- REQ-002: Parameter DATA_SIZE, default 4, SHALL set the number of 32-bit payload data words (matches C2SIF_DATA_SIZE).
- REQ-003: clk  in  1  sole clock; all logic SHALL be on its rising edge.
- REQ-004: rst  in  1  synchronous, active-high reset.
- REQ-005: s_req  in  NREQ  per-requester request level.
- REQ-006: s_ack  out  NREQ  per-requester acknowledge level.
- REQ-007: s_id, s_fn, s_addr  in  NREQ*32 each  per-requester header fields; port k occupies bits [32k+31:32k].
- REQ-008: s_data  in  NREQ*DATA_SIZE*32  per-requester payload; port k word i occupies bits [32(k*DATA_SIZE+i)+31 : 32(k*DATA_SIZE+i)].
- REQ-009: s_ret  out  NREQ*32  per-requester return value, same packing as s_id.
- REQ-010: m_req  out  1  downstream request.
- REQ-011: m_ack  in  1  downstream acknowledge.
- REQ-012: m_id, m_fn, m_addr  out  32 each; m_data  out  DATA_SIZE*32  forwarded payload.
- REQ-013: m_ret  in  32  downstream return value, valid while m_ack=1.
- REQ-014: grant  out  NREQ  one-hot owner of the downstream port, 0 when idle.
- REQ-015: busy  out  1  high whenever state is not IDLE.

Function
- REQ-016: Protocol on every port SHALL be four-phase level handshake: req rises with payload stable; ack rises with ret valid; req falls; ack falls.
- REQ-017: FSM states SHALL be IDLE, REQ, ACK, DRAIN; all outputs registered.
- REQ-018: IDLE: if any s_req bit is set, the arbiter SHALL pick the first set bit searching round-robin from ptr, latch its index g, copy its id/fn/addr/data to m_*, set grant[g]=1, m_req=1, and go to REQ; m_req SHALL rise exactly 1 cycle after s_req[g] is sampled high.
- REQ-019: REQ: m_* payload SHALL stay constant; on m_ack sampled 1, the arbiter SHALL register m_ret into s_ret[g], set s_ack[g]=1 in the same cycle, and go to ACK.
- REQ-020: ACK: on s_req[g] sampled 0, the arbiter SHALL clear s_ack[g] and m_req, and go to DRAIN; m_req SHALL stay 1 until then.
- REQ-021: DRAIN: on m_ack sampled 0, the arbiter SHALL clear grant, set ptr=(g+1) mod NREQ, and go to IDLE.
- REQ-022: No new grant SHALL be issued until m_ack has returned low.
- REQ-023: s_ret[k] SHALL hold its last value until port k next completes REQ.
- REQ-024: s_ack bits other than g SHALL be 0 at all times.
- REQ-025: If s_req[g] falls before m_ack rises, the transaction SHALL still complete downstream; s_ack[g] SHALL pulse for 1 cycle (REQ to ACK to DRAIN).
- REQ-026: Requests arriving during a transaction SHALL be held off (s_ack=0), never dropped.
- REQ-027: Best-case throughput SHALL be one transaction per 4 cycles plus downstream latency.

Reset
- REQ-028: rst=1 SHALL force state=IDLE, ptr=0, m_req=0, m_*=0, s_ack=0, s_ret=0, grant=0, busy=0 on the next edge, including mid-transaction.
- REQ-029: Requesters still holding s_req after reset SHALL be re-arbitrated from ptr=0.

Verification
- V1: Single port 2 sends id=5, fn=1, addr=0x100, m_ack after 3 cycles, m_ret=7 -> m_req 1 cycle after s_req; m_addr=0x100; s_ret[2]=7 with s_ack[2]; grant=0100 then 0.
- V2: All 4 s_req held high for 8 transactions -> grant order 0,1,2,3,0,1,2,3; no grant overlap; m_req never rises while m_ack=1.
- V3: Port 1 requests while port 0 in REQ -> s_ack[1]=0 until port 0 DRAIN ends; port 1 granted next.
- V4: rst asserted during REQ with m_req=1 -> next cycle all outputs 0, ptr=0; port 3 s_req still high -> granted again.
- V5: s_req[0] dropped before m_ack -> m_req held until m_ack; s_ack[0] high exactly 1 cycle; s_ret[0]=m_ret.

Source files
------------

// File: rtl/c2sif_arb.sv
`default_nettype none
// ============================================================================
// Module      : c2sif_arb
// Description : Round-robin arbiter that lets NREQ c2sif requesters share one
//               c2sif target. Every port uses a four-phase level handshake
//               (req up, ack up, req down, ack down). The downstream
//               transaction always runs to completion, even if the owning
//               requester withdraws early. All outputs are registered.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               s_req / s_ack       - per-requester handshake levels
//               s_id/s_fn/s_addr    - per-requester header, 32 bits per port
//               s_data              - per-requester payload, DATA_SIZE words
//               s_ret               - per-requester return value (held)
//               m_req / m_ack       - downstream handshake
//               m_id/m_fn/m_addr    - forwarded header
//               m_data / m_ret      - forwarded payload / downstream return
//               grant               - one-hot owner, 0 when idle
//               busy                - high whenever the arbiter is not idle
// Revision    : 1.0 - initial release
// ============================================================================
module c2sif_arb #(
    parameter int NREQ      = 4,
    parameter int DATA_SIZE = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NREQ-1:0]               s_req,
    output logic [NREQ-1:0]               s_ack,
    input  logic [NREQ*32-1:0]            s_id,
    input  logic [NREQ*32-1:0]            s_fn,
    input  logic [NREQ*32-1:0]            s_addr,
    input  logic [NREQ*DATA_SIZE*32-1:0]  s_data,
    output logic [NREQ*32-1:0]            s_ret,
    output logic                          m_req,
    input  logic                          m_ack,
    output logic [31:0]                   m_id,
    output logic [31:0]                   m_fn,
    output logic [31:0]                   m_addr,
    output logic [DATA_SIZE*32-1:0]       m_data,
    input  logic [31:0]                   m_ret,
    output logic [NREQ-1:0]               grant,
    output logic                          busy
);

    localparam int         c_iw       = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int         c_dw       = DATA_SIZE * 32;

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_req   = 2'd1;
    localparam logic [1:0] c_st_ack   = 2'd2;
    localparam logic [1:0] c_st_drain = 2'd3;

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic [c_iw-1:0] r_ptr;
    logic [c_iw-1:0] r_g;
    logic [c_iw-1:0] w_pick;
    logic            w_any;
    logic [c_iw-1:0] w_ptr_after_g;
    logic            r_busy;

    // Port index at a given round-robin distance from base, wrapping at NREQ.
    function automatic logic [c_iw-1:0] rr_idx(input logic [c_iw-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NREQ) begin
            sum = sum - NREQ;
        end
        return sum[c_iw-1:0];
    endfunction

    // Walk from the farthest offset back to the pointer so the closest
    // requesting port (in round-robin order) is the last one written.
    always_comb begin
        w_any  = 1'b0;
        w_pick = r_ptr;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (s_req[rr_idx(r_ptr, i)]) begin
                w_any  = 1'b1;
                w_pick = rr_idx(r_ptr, i);
            end
        end
    end

    assign w_ptr_after_g = (r_g == c_iw'(NREQ - 1)) ? '0 : r_g + c_iw'(1);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle:  if (w_any)         w_state_nxt = c_st_req;
            c_st_req:   if (m_ack)         w_state_nxt = c_st_ack;
            c_st_ack:   if (!s_req[r_g])   w_state_nxt = c_st_drain;
            c_st_drain: if (!m_ack)        w_state_nxt = c_st_idle;
            default:                       w_state_nxt = c_st_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
            r_ptr   <= '0;
            r_g     <= '0;
            r_busy  <= 1'b0;
            m_req   <= 1'b0;
            m_id    <= '0;
            m_fn    <= '0;
            m_addr  <= '0;
            m_data  <= '0;
            s_ack   <= '0;
            s_ret   <= '0;
            grant   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != c_st_idle);
            case (r_state)
                c_st_idle: begin
                    if (w_any) begin
                        r_g    <= w_pick;
                        grant  <= NREQ'(1) << w_pick;
                        m_req  <= 1'b1;
                        m_id   <= s_id[int'(w_pick)*32 +: 32];
                        m_fn   <= s_fn[int'(w_pick)*32 +: 32];
                        m_addr <= s_addr[int'(w_pick)*32 +: 32];
                        m_data <= s_data[int'(w_pick)*c_dw +: c_dw];
                    end
                end
                c_st_req: begin
                    // Return value is captured with the ack so the requester
                    // sees it valid as soon as s_ack rises.
                    if (m_ack) begin
                        s_ret[int'(r_g)*32 +: 32] <= m_ret;
                        s_ack[r_g]                <= 1'b1;
                    end
                end
                c_st_ack: begin
                    if (!s_req[r_g]) begin
                        s_ack <= '0;
                        m_req <= 1'b0;
                    end
                end
                c_st_drain: begin
                    // Hold the grant until the target has released m_ack so a
                    // new request never overlaps the old acknowledge.
                    if (!m_ack) begin
                        grant <= '0;
                        r_ptr <= w_ptr_after_g;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = r_busy;

endmodule
`default_nettype wire
